systolic_feeder: RTL and testbench
==================================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4, array dimension (rows of A = columns of B = N).
REQ-002 Parameter DW, default 8, signed operand width.
REQ-003 Parameter DRAIN_CYC, default 3, idle cycles after the last feed before done.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  upstream offers A and B.
REQ-007 in_ready  output  1  block can accept A and B this cycle.
REQ-008 a_in  input  N x N x DW signed  matrix A, [row][col].
REQ-009 b_in  input  N x N x DW signed  matrix B, [row][col].
REQ-010 acc_clr  output  1  one-cycle clear pulse to the downstream array accumulators.
REQ-011 feed_valid  output  1  a_feed and b_feed carry skewed operands.
REQ-012 a_feed  output  N x DW signed  left-edge inputs, one per array row.
REQ-013 b_feed  output  N x DW signed  top-edge inputs, one per array column.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; downstream array result is final.

Function
REQ-016 FSM states SHALL be IDLE, CLR, FEED, DRAIN, DONE.
REQ-017 in_ready SHALL be 1 in IDLE only; acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-018 On acceptance, a_in and b_in SHALL be latched into internal registers, and the state SHALL go IDLE -> CLR.
REQ-019 CLR SHALL last 1 cycle with acc_clr = 1, feed_valid = 0, and feeds = 0; then the state SHALL go to FEED with t = 0.
REQ-020 FEED SHALL last 2N-1 cycles (t = 0..2N-2, 3-bit counter for N = 4) with feed_valid = 1.
REQ-021 In FEED, a_feed[i] SHALL equal A[i][t-i] when 0 <= t-i < N, else 0.
REQ-022 In FEED, b_feed[j] SHALL equal B[t-j][j] when 0 <= t-j < N, else 0.
REQ-023 a_feed and b_feed SHALL be combinational from the latched matrices, t, and state, and SHALL be 0 outside FEED.
REQ-024 DRAIN SHALL last DRAIN_CYC cycles with feed_valid = 0; DONE SHALL last 1 cycle with done = 1; the state SHALL then return to IDLE.
REQ-025 Latency SHALL be 1 + (2N-1) + DRAIN_CYC + 1 = 12 cycles from the acceptance edge to the done pulse (N = 4, DRAIN_CYC = 3).
REQ-026 in_valid while busy SHALL be ignored, and the latched matrices SHALL NOT change.
REQ-027 If in_valid is held high, the next acceptance SHALL occur on the first IDLE cycle after DONE, so back-to-back jobs take 13 cycles each.
REQ-028 Changes to a_in or b_in after acceptance SHALL NOT affect the feeds.
REQ-029 No arithmetic is performed; operands SHALL pass through bit-exact, sign preserved.

Reset
REQ-030 While rst = 0: state = IDLE, t = 0, latched matrices = 0; outputs in_ready = 1, acc_clr = 0, feed_valid = 0, a_feed = 0, b_feed = 0, busy = 0, done = 0.
REQ-031 Reset asserted mid-operation SHALL abort the job immediately, and no done pulse SHALL follow.
REQ-032 After reset deasserts, in_valid SHALL be acceptable on the first rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the DW/N defaults, and the operand and feed-vector typedefs, for use by this block, the matmul4x4 array, and the benches.
REQ-034 One sub-module SHALL be used: skew_lane, the per-lane index/zero-select logic, instantiated 2N times (N for A, N for B).
REQ-035 Output ports SHALL connect directly to the a/b streaming inputs and clear input of a systolic matmul array.

Verification
REQ-036 Reset, then A = identity, B rows {1,2,3,4},{9,10,11,12},{17,14,19,20},{25,26,27,24}, accepted -> acc_clr at cycle 1; b_feed[0] = 1,9,17,25 at t = 0..3; b_feed[1] = 0,2,10,14,26 at t = 0..4; done at cycle 12.
REQ-037 Same job -> a_feed[1] = 0,0,1,0,0,0,0 and a_feed[3] = 0,0,0,0,0,0,1 over t = 0..6.
REQ-038 Signed: A[0][0] = -128, B[3][3] = -1 -> a_feed[0] = 8'h80 at t = 0; b_feed[3] = 8'hFF at t = 6.
REQ-039 in_valid held for 30 cycles -> acceptances at cycles 0 and 13; a_in changed at cycle 5 -> first job's feeds unchanged.
REQ-040 rst pulled low at t = 3 of FEED -> all outputs 0 asynchronously, no done; the new job is accepted on the first edge after release.

Source files
------------

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder, the downstream matmul array and benches.
package systolic_feeder_pkg;

  localparam int N_DEF     = 4;
  localparam int DW_DEF    = 8;
  localparam int DRAIN_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef logic signed [DW_DEF-1:0] operand_t;
  typedef operand_t    [N_DEF-1:0]  feed_vec_t;
  typedef feed_vec_t   [N_DEF-1:0]  matrix_t;

endpackage

// File: rtl/systolic_feeder_skew_lane.sv
// One skewed lane: presents i_vec[t - LANE] while that index is in range, else zero.
module skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int DW   = DW_DEF,
  parameter int TW   = 3,
  parameter int LANE = 0
) (
  input  logic [N-1:0][DW-1:0] i_vec,
  input  logic [TW-1:0]        i_t,
  input  logic                 i_en,
  output logic [DW-1:0]        o_feed
);

  // Index select by matching t against each lane-offset position; zero when none matches.
  always_comb begin
    o_feed = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_en && (i_t == TW'(LANE + k))) begin
        o_feed = i_vec[k];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Latches an A/B matrix pair and streams them as skewed edge operands into a systolic array.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DW        = DW_DEF,
  parameter int DRAIN_CYC = DRAIN_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0][N-1:0][DW-1:0] a_in,
  input  logic [N-1:0][N-1:0][DW-1:0] b_in,
  output logic                        acc_clr,
  output logic                        feed_valid,
  output logic [N-1:0][DW-1:0]        a_feed,
  output logic [N-1:0][DW-1:0]        b_feed,
  output logic                        busy,
  output logic                        done
);

  localparam int TW  = $clog2(2 * N);
  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(2 * N - 2);
  localparam logic [DCW-1:0] D_LAST = DCW'((DRAIN_CYC > 0) ? (DRAIN_CYC - 1) : 0);

  state_t                        r_state;
  logic [TW-1:0]                 r_t;
  logic [DCW-1:0]                r_drain;
  logic [N-1:0][N-1:0][DW-1:0]   r_a;
  logic [N-1:0][N-1:0][DW-1:0]   r_b;
  logic                          r_in_ready;
  logic                          r_acc_clr;
  logic                          r_feed_valid;
  logic                          r_busy;
  logic                          r_done;

  // Job sequencer: state, counters, latched matrices and registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_t          <= '0;
      r_drain      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_in_ready   <= 1'b1;
      r_acc_clr    <= 1'b0;
      r_feed_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_state    <= ST_CLR;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_acc_clr  <= 1'b1;
          end
        end
        ST_CLR: begin
          r_state      <= ST_FEED;
          r_t          <= '0;
          r_acc_clr    <= 1'b0;
          r_feed_valid <= 1'b1;
        end
        ST_FEED: begin
          if (r_t == T_LAST) begin
            r_t          <= '0;
            r_feed_valid <= 1'b0;
            r_drain      <= '0;
            if (DRAIN_CYC == 0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_drain == D_LAST) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign acc_clr    = r_acc_clr;
  assign feed_valid = r_feed_valid;
  assign busy       = r_busy;
  assign done       = r_done;

  // Row lanes take A row i directly; column lanes gather B column j across rows.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [N-1:0][DW-1:0] w_bcol;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign w_bcol[k] = r_b[k][g];
    end

    skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(g)) u_a_lane (
      .i_vec  (r_a[g]),
      .i_t    (r_t),
      .i_en   (r_feed_valid),
      .o_feed (a_feed[g])
    );

    skew_lane #(.N(N), .DW(DW), .TW(TW), .LANE(g)) u_b_lane (
      .i_vec  (w_bcol),
      .i_t    (r_t),
      .i_en   (r_feed_valid),
      .o_feed (b_feed[g])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: table-driven job trace plus corner-case sequences.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int N  = N_DEF;
  localparam int DW = DW_DEF;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      in_valid = 1'b0;
  matrix_t   a_in = '0;
  matrix_t   b_in = '0;
  feed_vec_t a_feed, b_feed;
  logic      in_ready, acc_clr, feed_valid, busy, done;
  logic [4:0] w_ctrl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign w_ctrl = {in_ready, acc_clr, feed_valid, busy, done};

  systolic_feeder #(.N(N), .DW(DW), .DRAIN_CYC(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .acc_clr    (acc_clr),
    .feed_valid (feed_valid),
    .a_feed     (a_feed),
    .b_feed     (b_feed),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [4:0]  ctrl;   // {in_ready, acc_clr, feed_valid, busy, done}
    logic [31:0] a_exp;  // {a3, a2, a1, a0}
    logic [31:0] b_exp;  // {b3, b2, b1, b0}
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_job1();
    a_in = '0;
    for (int i = 0; i < N; i++) a_in[i][i] = 8'sd1;
    b_in[0] = {8'd4,  8'd3,  8'd2,  8'd1};
    b_in[1] = {8'd12, 8'd11, 8'd10, 8'd9};
    b_in[2] = {8'd20, 8'd19, 8'd14, 8'd17};
    b_in[3] = {8'd24, 8'd27, 8'd26, 8'd25};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cyc[$];
    int first_done;
    int n_done;

    // Expected trace for job 1 (A = identity), cycles 1..13 after the accepting edge.
    tbl[0]  = '{5'b01010, 32'h00000000, 32'h00000000};
    tbl[1]  = '{5'b00110, 32'h00000001, 32'h00000001};
    tbl[2]  = '{5'b00110, 32'h00000000, 32'h00000209};
    tbl[3]  = '{5'b00110, 32'h00000100, 32'h00030A11};
    tbl[4]  = '{5'b00110, 32'h00000000, 32'h040B0E19};
    tbl[5]  = '{5'b00110, 32'h00010000, 32'h0C131A00};
    tbl[6]  = '{5'b00110, 32'h00000000, 32'h141B0000};
    tbl[7]  = '{5'b00110, 32'h01000000, 32'h18000000};
    tbl[8]  = '{5'b00010, 32'h00000000, 32'h00000000};
    tbl[9]  = '{5'b00010, 32'h00000000, 32'h00000000};
    tbl[10] = '{5'b00010, 32'h00000000, 32'h00000000};
    tbl[11] = '{5'b00011, 32'h00000000, 32'h00000000};
    tbl[12] = '{5'b10000, 32'h00000000, 32'h00000000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'(w_ctrl), 64'(5'b10000));
    chk("reset_afeed", 64'($unsigned(a_feed)), 64'd0);
    chk("reset_bfeed", 64'($unsigned(b_feed)), 64'd0);

    // Job 1: accepted on the first edge after reset release; busy-time in_valid and input changes ignored
    rst = 1'b1;
    load_job1();
    in_valid = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("job1_ctrl_c%0d", c), 64'(w_ctrl), 64'(tbl[c-1].ctrl));
      chk($sformatf("job1_afeed_c%0d", c), 64'($unsigned(a_feed)), 64'(tbl[c-1].a_exp));
      chk($sformatf("job1_bfeed_c%0d", c), 64'($unsigned(b_feed)), 64'(tbl[c-1].b_exp));
      in_valid = (c >= 3 && c <= 7);
      if (c == 5) begin
        a_in = {16{8'h5A}};
        b_in = {16{8'hA5}};
      end
    end

    // Signed pass-through
    a_in = '0;
    b_in = '0;
    a_in[0][0] = -8'sd128;
    b_in[3][3] = -8'sd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("signed_a0_t0", 64'($unsigned(a_feed[0])), 64'h80);
    chk("signed_afeed_t0", 64'($unsigned(a_feed)), 64'h00000080);
    repeat (6) @(negedge clk);
    chk("signed_b3_t6", 64'($unsigned(b_feed[3])), 64'hFF);
    chk("signed_bfeed_t6", 64'($unsigned(b_feed)), 64'hFF000000);
    repeat (5) @(negedge clk);
    chk("signed_idle_ctrl", 64'(w_ctrl), 64'(5'b10000));

    // in_valid held high: back-to-back acceptances, input change at cycle 5 only reaches job 2
    a_in = '0;
    b_in = '0;
    a_in[0][0] = 8'sh11;
    a_in[3][3] = 8'sh44;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (in_ready && in_valid) acc_cyc.push_back(cyc);
      if (cyc == 2)  chk("held_job1_a0", 64'($unsigned(a_feed[0])), 64'h11);
      if (cyc == 8)  chk("held_job1_a3", 64'($unsigned(a_feed[3])), 64'h44);
      if (cyc == 15) chk("held_job2_a0", 64'($unsigned(a_feed[0])), 64'h22);
      if (cyc == 21) chk("held_job2_a3", 64'($unsigned(a_feed[3])), 64'h99);
      if (cyc == 5) begin
        a_in[0][0] = 8'sh22;
        a_in[3][3] = -8'sd103;  // 8'h99
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("held_acc_count", 64'(acc_cyc.size()), 64'd3);
    if (acc_cyc.size() >= 3) begin
      chk("held_acc0", 64'(acc_cyc[0]), 64'd0);
      chk("held_acc1", 64'(acc_cyc[1]), 64'd13);
      chk("held_acc2", 64'(acc_cyc[2]), 64'd26);
    end
    repeat (12) @(negedge clk);
    chk("held_idle_ctrl", 64'(w_ctrl), 64'(5'b10000));

    // Reset during FEED at t = 3: asynchronous clear, no stale done, immediate re-acceptance
    load_job1();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_ctrl", 64'(w_ctrl), 64'(5'b00110));
    chk("abort_pre_bfeed", 64'($unsigned(b_feed)), 64'h040B0E19);
    #2 rst = 1'b0;
    #1;
    chk("abort_async_ctrl", 64'(w_ctrl), 64'(5'b10000));
    chk("abort_async_afeed", 64'($unsigned(a_feed)), 64'd0);
    chk("abort_async_bfeed", 64'($unsigned(b_feed)), 64'd0);
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    first_done = -1;
    n_done = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("restart_ctrl_c1", 64'(w_ctrl), 64'(5'b01010));
        in_valid = 1'b0;
      end
      if (c == 4) chk("restart_afeed_t2", 64'($unsigned(a_feed)), 64'h00000100);
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
    end
    chk("restart_done_cycle", 64'(first_done), 64'd12);
    chk("restart_done_count", 64'(n_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
